// File: rtl/game_sound_player.sv
// ============================================================================
// Module      : game_sound_player
// Description : Plays a 3-note square-wave win/lose jingle on a 1-bit audio pin
//               in response to one-cycle game events. Optional SOUND_MUTE_EN
//               adds a mute input that silences audio_out only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sound_player #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int NOTE_MS = 150,
  parameter int GAP_MS  = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win,
  input  logic       lose,
`ifdef SOUND_MUTE_EN
  input  logic       mute,
`endif
  output logic       audio_out,
  output logic       busy,
  output logic       done,
  output logic       melody,
  output logic [1:0] note_idx
);

  localparam int CYC_PER_MS  = CLK_HZ / 1000;
  localparam int NOTE_CYCLES = CYC_PER_MS * NOTE_MS;
  localparam int GAP_RAW     = CYC_PER_MS * GAP_MS;
  localparam int GAP_CYCLES  = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int DUR_MAX     = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DUR_W       = $clog2(DUR_MAX + 1);

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  // Half periods in clock cycles, truncated
  localparam logic [16:0] HP_C5 = 17'(CLK_HZ / (2 * 523));
  localparam logic [16:0] HP_E5 = 17'(CLK_HZ / (2 * 659));
  localparam logic [16:0] HP_G5 = 17'(CLK_HZ / (2 * 784));
  localparam logic [16:0] HP_G4 = 17'(CLK_HZ / (2 * 392));
  localparam logic [16:0] HP_E4 = 17'(CLK_HZ / (2 * 330));
  localparam logic [16:0] HP_C4 = 17'(CLK_HZ / (2 * 262));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [16:0]      tone_cnt;
  logic [16:0]      hp;
  logic [DUR_W-1:0] dur_cnt;
  logic             tone_level;
  logic             restart;
  logic             restart_mel;

  always_comb begin
    hp = HP_C5;
    case ({melody, note_idx})
      3'b000:  hp = HP_C5;
      3'b001:  hp = HP_E5;
      3'b010:  hp = HP_G5;
      3'b100:  hp = HP_G4;
      3'b101:  hp = HP_E4;
      3'b110:  hp = HP_C4;
      default: hp = HP_C5;
    endcase
  end

  // Lose always wins; a win only (re)starts from idle or over another win.
  always_comb begin
    restart     = 1'b0;
    restart_mel = 1'b0;
    if (lose) begin
      restart     = 1'b1;
      restart_mel = 1'b1;
    end else if (win && (state == IDLE || !melody)) begin
      restart     = 1'b1;
      restart_mel = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tone_cnt   <= '0;
      dur_cnt    <= '0;
      tone_level <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      melody     <= 1'b0;
      note_idx   <= 2'd0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        state      <= TONE;
        melody     <= restart_mel;
        note_idx   <= 2'd0;
        tone_cnt   <= '0;
        dur_cnt    <= '0;
        tone_level <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          TONE: begin
            if (dur_cnt == NOTE_LAST) begin
              state      <= GAP;
              dur_cnt    <= '0;
              tone_cnt   <= '0;
              tone_level <= 1'b0;
            end else begin
              dur_cnt <= dur_cnt + DUR_ONE;
              if (tone_cnt == hp - 17'd1) begin
                tone_cnt   <= '0;
                tone_level <= ~tone_level;
              end else begin
                tone_cnt <= tone_cnt + 17'd1;
              end
            end
          end
          GAP: begin
            if (dur_cnt == GAP_LAST) begin
              dur_cnt <= '0;
              if (note_idx == 2'd2) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= TONE;
                note_idx <= note_idx + 2'd1;
              end
            end else begin
              dur_cnt <= dur_cnt + DUR_ONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SOUND_MUTE_EN
  // Tone phase keeps running under mute so release resumes mid-waveform
  assign audio_out = tone_level & ~mute;
`else
  assign audio_out = tone_level;
`endif

endmodule

`default_nettype wire
